// File: rtl/fx2_slave_fifo_model.sv
// rtl/fx2_slave_fifo_model.sv - FX2 slave-FIFO responder: EP2/EP4 OUT, EP6 IN with packet commit
// Optional: define FX2_PKTEND_EN to add usb_pktend (partial/zero-length commit) and zlp_count.
module fx2_slave_fifo_model #(
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int PKT_WORDS = 256
) (
  input  logic          fpga_gclk,
  input  logic          reset,
  input  logic [1:0]    usb_fifoaddr,
  input  logic          usb_slcs,
  input  logic          usb_sloe,
  input  logic          usb_slrd,
  input  logic          usb_slwr,
`ifdef FX2_PKTEND_EN
  input  logic          usb_pktend,
  output logic [7:0]    zlp_count,
`endif
  input  logic [DW-1:0] usb_fd_i,
  output logic [DW-1:0] usb_fd_o,
  output logic          usb_fd_oe,
  output logic          usb_flaga,
  output logic          usb_flagb,
  output logic          usb_flagc,
  input  logic          h_out_valid,
  input  logic          h_out_ep,
  input  logic [DW-1:0] h_out_data,
  output logic          h_out_ready,
  output logic          h_in_valid,
  output logic [DW-1:0] h_in_data,
  input  logic          h_in_ready,
  output logic          err_underflow,
  output logic          err_overflow,
  output logic          err_collision
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PKT = PKT_WORDS[AW:0];

  typedef enum logic [1:0] {S_COLLECT, S_COMMIT, S_ZLP} state_t;

  // FIFO index 0 = EP2, 1 = EP4, 2 = EP6
  logic [DW-1:0] mem [3][DEPTH];
  logic [AW:0]   wp [3];
  logic [AW:0]   rp [3];
  logic [DW-1:0] din [3];
  logic [2:0]    push, pop, empty, full;

  logic          sel, rd_req, wr_req, rd_only, wr_only, pktend_req;
  logic [DW-1:0] head0, head1;
  state_t        state;
  logic [AW:0]   uncommitted, committed, cnt_inc;

  assign sel     = !usb_slcs;
  assign rd_req  = sel & !usb_slrd;
  assign wr_req  = sel & !usb_slwr;
  assign rd_only = rd_req & !wr_req;
  assign wr_only = wr_req & !rd_req;

`ifdef FX2_PKTEND_EN
  assign pktend_req = sel & !usb_pktend & (usb_fifoaddr == 2'd2);
`else
  assign pktend_req = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
    end
  end

  assign h_out_ready = h_out_ep ? !full[1] : !full[0];
  assign h_in_valid  = (committed != '0);

  assign din[0]  = h_out_data;
  assign din[1]  = h_out_data;
  assign din[2]  = usb_fd_i;
  assign push[0] = h_out_valid & h_out_ready & !h_out_ep;
  assign push[1] = h_out_valid & h_out_ready & h_out_ep;
  assign push[2] = wr_only & (usb_fifoaddr == 2'd2) & !full[2];
  assign pop[0]  = rd_only & (usb_fifoaddr == 2'd0) & !empty[0];
  assign pop[1]  = rd_only & (usb_fifoaddr == 2'd1) & !empty[1];
  assign pop[2]  = h_in_valid & h_in_ready;

  assign head0     = mem[0][rp[0][AW-1:0]];
  assign head1     = mem[1][rp[1][AW-1:0]];
  assign h_in_data = mem[2][rp[2][AW-1:0]];

  assign usb_fd_oe = sel & !usb_sloe & !usb_fifoaddr[1];
  assign usb_fd_o  = !usb_fd_oe ? '0 : (usb_fifoaddr[0] ? head1 : head0);

  assign usb_flaga = !empty[0];
  assign usb_flagb = !empty[1];
  assign usb_flagc = !full[2];

  always_ff @(posedge fpga_gclk) begin
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wp[i][AW-1:0]] <= din[i];
  end

  always_ff @(posedge fpga_gclk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_gclk) begin
    if (reset) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      if (rd_only && !usb_fifoaddr[1] && empty[{1'b0, usb_fifoaddr[0]}]) err_underflow <= 1'b1;
      if (wr_only && usb_fifoaddr == 2'd2 && full[2]) err_overflow <= 1'b1;
      if (rd_req && wr_req) err_collision <= 1'b1;
    end
  end

  // cnt_inc includes a write landing this cycle, so a packet closes on its last word
  assign cnt_inc = uncommitted + {{AW{1'b0}}, push[2]};

  always_ff @(posedge fpga_gclk) begin
    if (reset) begin
      state       <= S_COLLECT;
      uncommitted <= '0;
      committed   <= '0;
`ifdef FX2_PKTEND_EN
      zlp_count   <= '0;
`endif
    end else begin
      case (state)
        S_COMMIT: begin
          committed   <= committed + uncommitted - {{AW{1'b0}}, pop[2]};
          uncommitted <= {{AW{1'b0}}, push[2]};
          state       <= S_COLLECT;
        end
        S_ZLP: begin
          committed   <= committed - {{AW{1'b0}}, pop[2]};
          uncommitted <= cnt_inc;
`ifdef FX2_PKTEND_EN
          zlp_count   <= zlp_count + 8'd1;
`endif
          state       <= S_COLLECT;
        end
        default: begin
          committed   <= committed - {{AW{1'b0}}, pop[2]};
          uncommitted <= cnt_inc;
          if (cnt_inc == PKT || (pktend_req && cnt_inc != '0)) state <= S_COMMIT;
          else if (pktend_req)                                 state <= S_ZLP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// tb/tb_fx2_slave_fifo_model.sv - scoreboard bench for fx2_slave_fifo_model
module tb_fx2_slave_fifo_model;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    usb_fifoaddr;
  logic          usb_slcs, usb_sloe, usb_slrd, usb_slwr;
  logic [DW-1:0] usb_fd_i, usb_fd_o;
  logic          usb_fd_oe, usb_flaga, usb_flagb, usb_flagc;
  logic          h_out_valid, h_out_ep, h_out_ready;
  logic [DW-1:0] h_out_data, h_in_data;
  logic          h_in_valid, h_in_ready;
  logic          err_underflow, err_overflow, err_collision;
`ifdef FX2_PKTEND_EN
  logic          usb_pktend;
  logic [7:0]    zlp_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q2[$], q4[$], q6[$];
  logic [DW-1:0] exp_w;

  always #5 clk = ~clk;

  fx2_slave_fifo_model dut (
    .fpga_gclk(clk), .reset(reset), .usb_fifoaddr(usb_fifoaddr),
    .usb_slcs(usb_slcs), .usb_sloe(usb_sloe), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
`ifdef FX2_PKTEND_EN
    .usb_pktend(usb_pktend), .zlp_count(zlp_count),
`endif
    .usb_fd_i(usb_fd_i), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
    .usb_flaga(usb_flaga), .usb_flagb(usb_flagb), .usb_flagc(usb_flagc),
    .h_out_valid(h_out_valid), .h_out_ep(h_out_ep), .h_out_data(h_out_data),
    .h_out_ready(h_out_ready), .h_in_valid(h_in_valid), .h_in_data(h_in_data),
    .h_in_ready(h_in_ready), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_collision(err_collision)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    usb_slcs = 1'b1; usb_sloe = 1'b1; usb_slrd = 1'b1; usb_slwr = 1'b1;
    usb_fifoaddr = 2'd0; usb_fd_i = '0;
    h_out_valid = 1'b0; h_out_ep = 1'b0; h_out_data = '0; h_in_ready = 1'b0;
`ifdef FX2_PKTEND_EN
    usb_pktend = 1'b1;
`endif
  endtask

  task automatic ep6_write_block(input int n, input int base);
    usb_slcs = 1'b0; usb_sloe = 1'b1; usb_fifoaddr = 2'd2;
    for (int i = 0; i < n; i++) begin
      usb_fd_i = DW'(base + i);
      usb_slwr = 1'b0;
      q6.push_back(DW'(base + i));
      tick();
    end
    usb_slwr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({usb_flaga, usb_flagb, usb_flagc} !== 3'b001) begin
      miscompares++; $display("FAIL reset_flags got %b exp 001", {usb_flaga, usb_flagb, usb_flagc});
    end
    vectors++;
    if ({usb_fd_oe, usb_fd_o} !== {1'b0, 16'h0000}) begin
      miscompares++; $display("FAIL reset_fd got oe=%b d=%h exp oe=0 d=0000", usb_fd_oe, usb_fd_o);
    end
    vectors++;
    if ({h_in_valid, h_out_ready} !== 2'b01) begin
      miscompares++; $display("FAIL reset_host got %b exp 01", {h_in_valid, h_out_ready});
    end
    vectors++;
    if ({err_underflow, err_overflow, err_collision} !== 3'b000) begin
      miscompares++; $display("FAIL reset_err got %b exp 000", {err_underflow, err_overflow, err_collision});
    end
  endtask

  task automatic test_ep2_basic();
    h_out_ep = 1'b0; h_out_valid = 1'b1;
    h_out_data = 16'h1111; q2.push_back(16'h1111);
    tick();
    vectors++;
    if (usb_flaga !== 1'b1) begin
      miscompares++; $display("FAIL ep2_flaga_rise got %b exp 1", usb_flaga);
    end
    h_out_data = 16'h2222; q2.push_back(16'h2222);
    tick();
    h_out_valid = 1'b0;
    usb_slcs = 1'b0; usb_sloe = 1'b0; usb_fifoaddr = 2'd0;
    #1;
    vectors++;
    if (usb_fd_oe !== 1'b1) begin
      miscompares++; $display("FAIL ep2_oe got %b exp 1", usb_fd_oe);
    end
    exp_w = q2.pop_front();
    vectors++;
    if (usb_fd_o !== exp_w) begin
      miscompares++; $display("FAIL ep2_head0 got %h exp %h", usb_fd_o, exp_w);
    end
    usb_slrd = 1'b0; tick(); usb_slrd = 1'b1; #1;
    exp_w = q2.pop_front();
    vectors++;
    if (usb_fd_o !== exp_w) begin
      miscompares++; $display("FAIL ep2_head1 got %h exp %h", usb_fd_o, exp_w);
    end
    usb_slrd = 1'b0; tick(); usb_slrd = 1'b1; #1;
    vectors++;
    if (usb_flaga !== 1'b0) begin
      miscompares++; $display("FAIL ep2_flaga_fall got %b exp 0", usb_flaga);
    end
    idle(); #1;
  endtask

  task automatic test_ep2_full();
    h_out_ep = 1'b0; h_out_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      h_out_data = DW'(16'hA000 + i);
      q2.push_back(DW'(16'hA000 + i));
      tick();
    end
    h_out_valid = 1'b0; #1;
    vectors++;
    if (h_out_ready !== 1'b0) begin
      miscompares++; $display("FAIL ep2_full_ready got %b exp 0", h_out_ready);
    end
    h_out_ep = 1'b1; #1;
    vectors++;
    if (h_out_ready !== 1'b1) begin
      miscompares++; $display("FAIL ep4_ready got %b exp 1", h_out_ready);
    end
    h_out_valid = 1'b1; h_out_data = 16'h4444; q4.push_back(16'h4444);
    tick();
    h_out_valid = 1'b0; #1;
    vectors++;
    if (usb_flagb !== 1'b1) begin
      miscompares++; $display("FAIL ep4_flagb got %b exp 1", usb_flagb);
    end
    // drain EP2 at one word per cycle with slrd held low
    usb_slcs = 1'b0; usb_sloe = 1'b0; usb_fifoaddr = 2'd0; usb_slrd = 1'b0; #1;
    for (int i = 0; i < 256; i++) begin
      exp_w = q2.pop_front();
      vectors++;
      if (usb_fd_o !== exp_w) begin
        miscompares++; $display("FAIL ep2_drain[%0d] got %h exp %h", i, usb_fd_o, exp_w);
      end
      tick();
    end
    usb_slrd = 1'b1; #1;
    vectors++;
    if (usb_flaga !== 1'b0) begin
      miscompares++; $display("FAIL ep2_drained_flaga got %b exp 0", usb_flaga);
    end
    usb_fifoaddr = 2'd1; #1;
    exp_w = q4.pop_front();
    vectors++;
    if (usb_fd_o !== exp_w) begin
      miscompares++; $display("FAIL ep4_head got %h exp %h", usb_fd_o, exp_w);
    end
    usb_slrd = 1'b0; tick(); usb_slrd = 1'b1; #1;
    vectors++;
    if (usb_flagb !== 1'b0) begin
      miscompares++; $display("FAIL ep4_flagb_fall got %b exp 0", usb_flagb);
    end
    idle(); #1;
  endtask

  task automatic test_ep6_packet();
    ep6_write_block(255, 0);
    vectors++;
    if ({usb_flagc, h_in_valid} !== 2'b10) begin
      miscompares++; $display("FAIL ep6_255 got flagc,valid=%b exp 10", {usb_flagc, h_in_valid});
    end
    ep6_write_block(1, 255);
    vectors++;
    if ({usb_flagc, h_in_valid} !== 2'b00) begin
      miscompares++; $display("FAIL ep6_256 got flagc,valid=%b exp 00", {usb_flagc, h_in_valid});
    end
    tick();
    vectors++;
    if (h_in_valid !== 1'b1) begin
      miscompares++; $display("FAIL ep6_commit got %b exp 1", h_in_valid);
    end
    h_in_ready = 1'b1; #1;
    for (int i = 0; i < 256; i++) begin
      exp_w = q6.pop_front();
      vectors++;
      if (h_in_valid !== 1'b1 || h_in_data !== exp_w) begin
        miscompares++; $display("FAIL ep6_read[%0d] got v=%b d=%h exp v=1 d=%h", i, h_in_valid, h_in_data, exp_w);
      end
      tick();
    end
    h_in_ready = 1'b0; #1;
    vectors++;
    if ({h_in_valid, usb_flagc} !== 2'b01) begin
      miscompares++; $display("FAIL ep6_empty got valid,flagc=%b exp 01", {h_in_valid, usb_flagc});
    end
    idle(); #1;
  endtask

  task automatic test_errors();
    usb_slcs = 1'b0; usb_sloe = 1'b0; usb_fifoaddr = 2'd1;
    usb_slrd = 1'b0; tick(); usb_slrd = 1'b1;
    tick(); tick();
    vectors++;
    if ({err_underflow, usb_flagb} !== 2'b10) begin
      miscompares++; $display("FAIL underflow got err,flagb=%b exp 10", {err_underflow, usb_flagb});
    end
    ep6_write_block(256, 16'h0300);
    usb_fd_i = 16'hDEAD; usb_slwr = 1'b0; tick(); usb_slwr = 1'b1; #1;
    vectors++;
    if (err_overflow !== 1'b1) begin
      miscompares++; $display("FAIL overflow got %b exp 1", err_overflow);
    end
    usb_slcs = 1'b1; h_in_ready = 1'b1; #1;
    for (int i = 0; i < 256; i++) begin
      int budget;
      budget = 0;
      while (!h_in_valid && budget < 8) begin tick(); budget++; end
      exp_w = q6.pop_front();
      vectors++;
      if (h_in_valid !== 1'b1 || h_in_data !== exp_w) begin
        miscompares++; $display("FAIL ovf_read[%0d] got v=%b d=%h exp v=1 d=%h", i, h_in_valid, h_in_data, exp_w);
      end
      tick();
    end
    h_in_ready = 1'b0; tick(); tick();
    vectors++;
    if ({h_in_valid, usb_flagc, err_underflow} !== 3'b011) begin
      miscompares++; $display("FAIL ovf_dropped got valid,flagc,uflow=%b exp 011", {h_in_valid, usb_flagc, err_underflow});
    end
    idle();
    h_out_ep = 1'b0; h_out_valid = 1'b1; h_out_data = 16'h5555; q2.push_back(16'h5555);
    tick();
    h_out_valid = 1'b0;
    usb_slcs = 1'b0; usb_sloe = 1'b0; usb_fifoaddr = 2'd0;
    usb_slrd = 1'b0; usb_slwr = 1'b0; tick();
    usb_slrd = 1'b1; usb_slwr = 1'b1; #1;
    vectors++;
    if ({usb_flaga, err_collision} !== 2'b11) begin
      miscompares++; $display("FAIL collision got flaga,err=%b exp 11", {usb_flaga, err_collision});
    end
    exp_w = q2.pop_front();
    vectors++;
    if (usb_fd_o !== exp_w) begin
      miscompares++; $display("FAIL collision_head got %h exp %h", usb_fd_o, exp_w);
    end
    usb_slrd = 1'b0; tick(); usb_slrd = 1'b1; #1;
    vectors++;
    if (usb_flaga !== 1'b0) begin
      miscompares++; $display("FAIL collision_pop got %b exp 0", usb_flaga);
    end
    idle(); #1;
  endtask

`ifdef FX2_PKTEND_EN
  task automatic test_pktend();
    int budget;
    ep6_write_block(3, 16'h0700);
    usb_pktend = 1'b0; tick(); usb_pktend = 1'b1;
    budget = 0;
    while (!h_in_valid && budget < 8) begin tick(); budget++; end
    h_in_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      exp_w = q6.pop_front();
      vectors++;
      if (h_in_valid !== 1'b1 || h_in_data !== exp_w) begin
        miscompares++; $display("FAIL pkt_read[%0d] got v=%b d=%h exp v=1 d=%h", i, h_in_valid, h_in_data, exp_w);
      end
      tick();
    end
    h_in_ready = 1'b0; #1;
    vectors++;
    if (h_in_valid !== 1'b0) begin
      miscompares++; $display("FAIL pkt_done got %b exp 0", h_in_valid);
    end
    usb_slcs = 1'b0; usb_fifoaddr = 2'd2;
    usb_pktend = 1'b0; tick(); usb_pktend = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({zlp_count, h_in_valid} !== {8'd1, 1'b0}) begin
      miscompares++; $display("FAIL zlp got cnt=%0d v=%b exp cnt=1 v=0", zlp_count, h_in_valid);
    end
    idle(); #1;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ep2_basic();
    test_ep2_full();
    test_ep6_packet();
    test_errors();
`ifdef FX2_PKTEND_EN
    test_pktend();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
